// File: rtl/hood_pkg.sv
// hood_pkg: shared definitions for the range-hood timekeeping core.
//   - mode and display-select encodings
//   - BCD field widths
//   - elaboration-time helpers that turn decimal constants into packed BCD
package hood_pkg;

    localparam int BCD_DIGIT_W = 4;                 // one BCD digit
    localparam int BCD_FIELD_W = 2 * BCD_DIGIT_W;   // one hh / mm / ss field
    localparam int HMS_W       = 3 * BCD_FIELD_W;   // hh:mm:ss

    typedef enum logic [2:0] {
        MODE_STANDBY = 3'd0,
        MODE_LOW     = 3'd1,
        MODE_HIGH    = 3'd2,
        MODE_TURBO   = 3'd3,
        MODE_CLEAN   = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        DISP_TOD   = 2'd0,
        DISP_CUM   = 2'd1,
        DISP_CD    = 2'd2,
        DISP_BLANK = 2'd3
    } disp_sel_e;

    // Two-digit BCD of a value in 0..99 (elaboration-time constants only).
    function automatic logic [BCD_FIELD_W-1:0] to_bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Seconds (0..5999) to a 00:mm:ss BCD word.
    function automatic logic [HMS_W-1:0] secs_to_mmss(input int s);
        return {8'h00, to_bcd2(s / 60), to_bcd2(s % 60)};
    endfunction

endpackage

// File: rtl/bcd_hms_counter.sv
// bcd_hms_counter: hh:mm:ss counter held directly in packed BCD.
//   Parameters: HR_MAX (highest hour value), WRAP (1 = wrap to zero after
//   HR_MAX:59:59, 0 = saturate there).
//   Ports: clk_1hz/rst (async active-low), clr > load > inc > dec priority,
//   load_val (BCD hh:mm:ss), count (current BCD value).
//   Decrement stops at zero. The minutes field decrements correctly from any
//   BCD value up to 99, so a mm:ss countdown longer than an hour can be
//   loaded straight into the mm/ss fields.
module bcd_hms_counter
    import hood_pkg::*;
#(
    parameter int HR_MAX = 23,
    parameter bit WRAP   = 1'b1
) (
    input  logic             clk_1hz,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    input  logic             load,
    input  logic [HMS_W-1:0] load_val,
    output logic [HMS_W-1:0] count
);

    localparam logic [BCD_FIELD_W-1:0] HR_BCD = to_bcd2(HR_MAX);
    localparam logic [BCD_FIELD_W-1:0] MS_MAX = 8'h59;
    localparam logic [HMS_W-1:0]       FULL   = {HR_BCD, MS_MAX, MS_MAX};

    function automatic logic [BCD_FIELD_W-1:0] bcd_inc(
        input logic [BCD_FIELD_W-1:0] v,
        input logic [BCD_FIELD_W-1:0] max
    );
        if (v == max)
            return '0;
        else if (v[BCD_DIGIT_W-1:0] == 4'd9)
            return {v[BCD_FIELD_W-1:BCD_DIGIT_W] + 4'd1, 4'd0};
        else
            return {v[BCD_FIELD_W-1:BCD_DIGIT_W], v[BCD_DIGIT_W-1:0] + 4'd1};
    endfunction

    function automatic logic [BCD_FIELD_W-1:0] bcd_dec(
        input logic [BCD_FIELD_W-1:0] v,
        input logic [BCD_FIELD_W-1:0] max
    );
        if (v == '0)
            return max;
        else if (v[BCD_DIGIT_W-1:0] == 4'd0)
            return {v[BCD_FIELD_W-1:BCD_DIGIT_W] - 4'd1, 4'd9};
        else
            return {v[BCD_FIELD_W-1:BCD_DIGIT_W], v[BCD_DIGIT_W-1:0] - 4'd1};
    endfunction

    logic [HMS_W-1:0]       count_q, count_d;
    logic [BCD_FIELD_W-1:0] hh, mm, ss;

    assign hh = count_q[23:16];
    assign mm = count_q[15:8];
    assign ss = count_q[7:0];

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (inc) begin
            if (WRAP || (count_q != FULL)) begin
                count_d[7:0] = bcd_inc(ss, MS_MAX);
                if (ss == MS_MAX) begin
                    count_d[15:8] = bcd_inc(mm, MS_MAX);
                    if (mm == MS_MAX)
                        count_d[23:16] = bcd_inc(hh, HR_BCD);
                end
            end
        end else if (dec) begin
            if (count_q != '0) begin
                count_d[7:0] = bcd_dec(ss, MS_MAX);
                if (ss == '0) begin
                    count_d[15:8] = bcd_dec(mm, MS_MAX);
                    if (mm == '0)
                        count_d[23:16] = bcd_dec(hh, HR_BCD);
                end
            end
        end
    end

    always_ff @(posedge clk_1hz or negedge rst) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/hood_time_keeper.sv
// hood_time_keeper: timekeeping core of the range-hood controller.
//   Runs time of day, cumulative fan time and the turbo/self-clean countdown
//   on the 1 Hz tick and packs the selected one into a BCD display word.
//   Ports:
//     clk_1hz, rst (async active-low)
//     power_on       machine on (level)
//     mode           0 standby,1 low,2 high,3 turbo,4 clean; 5-7 = standby
//     disp_sel       0 tod, 1 cumulative, 2 countdown, 3 blank
//     time_data      {8'h00, hh, mm, ss} packed BCD
//     cd_done        one-cycle pulse when a countdown runs out
//     clean_reminder cumulative hours >= WORK_LIMIT_HRS (registered)
//     cd_active      countdown nonzero
module hood_time_keeper
    import hood_pkg::*;
#(
    parameter int TURBO_SECS     = 60,
    parameter int CLEAN_SECS     = 180,
    parameter int WORK_LIMIT_HRS = 10
) (
    input  logic        clk_1hz,
    input  logic        rst,
    input  logic        power_on,
    input  logic [2:0]  mode,
    input  logic [1:0]  disp_sel,
    output logic [31:0] time_data,
    output logic        cd_done,
    output logic        clean_reminder,
    output logic        cd_active
);

    localparam logic [HMS_W-1:0]       TURBO_LOAD = secs_to_mmss(TURBO_SECS);
    localparam logic [HMS_W-1:0]       CLEAN_LOAD = secs_to_mmss(CLEAN_SECS);
    localparam logic [BCD_FIELD_W-1:0] LIMIT_BCD  = to_bcd2(WORK_LIMIT_HRS);

    mode_e            eff_mode, mode_q, mode_d;
    logic             power_q, power_d;
    logic             cd_done_q, cd_done_d;
    logic             clean_reminder_q, clean_reminder_d;
    logic [HMS_W-1:0] tod_cnt, cum_cnt, cd_cnt, cd_load_val;
    logic             mode_chg, cd_mode, cd_expire;
    logic             tod_clr, tod_inc, cum_inc, cum_clr;
    logic             cd_load, cd_clr, cd_dec;

    always_comb begin
        eff_mode = MODE_STANDBY;
        if (power_on) begin
            case (mode)
                3'd1:    eff_mode = MODE_LOW;
                3'd2:    eff_mode = MODE_HIGH;
                3'd3:    eff_mode = MODE_TURBO;
                3'd4:    eff_mode = MODE_CLEAN;
                default: eff_mode = MODE_STANDBY;
            endcase
        end
    end

    assign mode_chg = (eff_mode != mode_q);
    assign cd_mode  = (eff_mode == MODE_TURBO) || (eff_mode == MODE_CLEAN);

    // A mode change on the expiry tick takes precedence, so expiry requires
    // the mode to be unchanged.
    assign cd_expire = !mode_chg && (cd_cnt == 24'h000001);

    assign tod_clr = power_on && !power_q;
    assign tod_inc = power_on && power_q;

    assign cum_inc = (eff_mode == MODE_LOW) || (eff_mode == MODE_HIGH) ||
                     (eff_mode == MODE_TURBO);
    assign cum_clr = cd_expire && (eff_mode == MODE_CLEAN);

    assign cd_load     = mode_chg && cd_mode;
    assign cd_clr      = mode_chg && !cd_mode;
    assign cd_dec      = !mode_chg && (cd_cnt != '0);
    assign cd_load_val = (eff_mode == MODE_TURBO) ? TURBO_LOAD : CLEAN_LOAD;

    bcd_hms_counter #(.HR_MAX(23), .WRAP(1'b1)) u_tod (
        .clk_1hz (clk_1hz),
        .rst     (rst),
        .inc     (tod_inc),
        .dec     (1'b0),
        .clr     (tod_clr),
        .load    (1'b0),
        .load_val('0),
        .count   (tod_cnt)
    );

    bcd_hms_counter #(.HR_MAX(99), .WRAP(1'b0)) u_cum (
        .clk_1hz (clk_1hz),
        .rst     (rst),
        .inc     (cum_inc),
        .dec     (1'b0),
        .clr     (cum_clr),
        .load    (1'b0),
        .load_val('0),
        .count   (cum_cnt)
    );

    bcd_hms_counter #(.HR_MAX(99), .WRAP(1'b0)) u_cd (
        .clk_1hz (clk_1hz),
        .rst     (rst),
        .inc     (1'b0),
        .dec     (cd_dec),
        .clr     (cd_clr),
        .load    (cd_load),
        .load_val(cd_load_val),
        .count   (cd_cnt)
    );

    always_comb begin
        power_d          = power_on;
        mode_d           = eff_mode;
        cd_done_d        = cd_expire;
        clean_reminder_d = (cum_cnt[23:16] >= LIMIT_BCD);
    end

    always_ff @(posedge clk_1hz or negedge rst) begin
        if (!rst) begin
            power_q          <= 1'b0;
            mode_q           <= MODE_STANDBY;
            cd_done_q        <= 1'b0;
            clean_reminder_q <= 1'b0;
        end else begin
            power_q          <= power_d;
            mode_q           <= mode_d;
            cd_done_q        <= cd_done_d;
            clean_reminder_q <= clean_reminder_d;
        end
    end

    always_comb begin
        time_data = 32'h0;
        case (disp_sel)
            DISP_TOD: time_data = {8'h00, tod_cnt};
            DISP_CUM: time_data = {8'h00, cum_cnt};
            DISP_CD:  time_data = {16'h0000, cd_cnt[15:0]};
            default:  time_data = 32'h0;
        endcase
    end

    assign cd_done        = cd_done_q;
    assign clean_reminder = clean_reminder_q;
    assign cd_active      = (cd_cnt != '0);

endmodule

// File: tb/tb_hood_time_keeper.sv
module tb_hood_time_keeper;

    logic        clk_1hz = 1'b0;
    logic        rst;
    logic        power_on;
    logic [2:0]  mode;
    logic [1:0]  disp_sel;
    logic [31:0] time_data;
    logic        cd_done, clean_reminder, cd_active;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    hood_time_keeper #(.TURBO_SECS(60), .CLEAN_SECS(180), .WORK_LIMIT_HRS(1)) dut (
        .clk_1hz       (clk_1hz),
        .rst           (rst),
        .power_on      (power_on),
        .mode          (mode),
        .disp_sel      (disp_sel),
        .time_data     (time_data),
        .cd_done       (cd_done),
        .clean_reminder(clean_reminder),
        .cd_active     (cd_active)
    );

    always #5 clk_1hz = ~clk_1hz;

    // Count every cycle in which cd_done is high, sampled mid-cycle.
    always @(posedge clk_1hz) begin
        #2;
        if (cd_done === 1'b1) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        pwr;
        logic [2:0]  md;
        logic [1:0]  sel;
        int          n;      // ticks to apply; 0 = combinational check only
        logic [31:0] data;
        logic        done;
        logic        act;
        logic        rem;
        int          dcnt;   // cd_done cycles seen so far
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic p, input logic [2:0] m, input logic [1:0] s,
                       input int n, input logic [31:0] d, input logic dn,
                       input logic a, input logic r, input int dc);
        vec_t v;
        v.pwr = p; v.md = m; v.sel = s; v.n = n; v.data = d;
        v.done = dn; v.act = a; v.rem = r; v.dcnt = dc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    initial begin
        // ---------------- reset held with arbitrary inputs ----------------
        rst = 1'b0; power_on = 1'b1; mode = 3'd3; disp_sel = 2'd0;
        repeat (3) @(negedge clk_1hz);
        for (int s = 0; s < 4; s++) begin
            disp_sel = 2'(s);
            #1;
            chk($sformatf("rst_data_sel%0d", s), time_data, 32'h0);
        end
        chk("rst_done", {31'b0, cd_done}, 32'h0);
        chk("rst_rem", {31'b0, clean_reminder}, 32'h0);
        chk("rst_act", {31'b0, cd_active}, 32'h0);

        // ---------------- release while off: nothing moves ----------------
        @(negedge clk_1hz);
        power_on = 1'b0; mode = 3'd0; disp_sel = 2'd0; rst = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk_1hz);
            chk($sformatf("off_tick%0d", t), time_data, 32'h0);
        end

        // ---------------- directed table ----------------
        //  pwr mode sel  ticks  time_data     done act rem dcnt
        add(1, 0, 0,     1, 32'h0000_0000, 0, 0, 0, 0); // power rise clears tod
        add(1, 1, 0,  3661, 32'h0001_0101, 0, 0, 1, 0); // tod 01:01:01
        add(1, 1, 1,     0, 32'h0001_0101, 0, 0, 1, 0); // cum 01:01:01
        add(1, 3, 2,     1, 32'h0000_0100, 0, 1, 1, 0); // turbo load 01:00
        add(1, 3, 2,    59, 32'h0000_0001, 0, 1, 1, 0);
        add(1, 3, 2,     1, 32'h0000_0000, 1, 0, 1, 1); // expiry pulse
        add(1, 3, 2,     1, 32'h0000_0000, 0, 0, 1, 1); // pulse gone, holds 0
        add(1, 4, 2,     1, 32'h0000_0300, 0, 1, 1, 1); // clean load 03:00
        add(1, 4, 2,    10, 32'h0000_0250, 0, 1, 1, 1);
        add(1, 2, 2,     1, 32'h0000_0000, 0, 0, 1, 1); // abort, no pulse
        add(1, 4, 2,     1, 32'h0000_0300, 0, 1, 1, 1);
        add(1, 4, 2,   179, 32'h0000_0001, 0, 1, 1, 1);
        add(1, 4, 2,     1, 32'h0000_0000, 1, 0, 1, 2); // clean expiry
        add(1, 4, 1,     0, 32'h0000_0000, 1, 0, 1, 2); // cum cleared same tick
        add(1, 4, 1,     1, 32'h0000_0000, 0, 0, 0, 2); // reminder drops next tick
        add(1, 2, 1,  3600, 32'h0001_0000, 0, 0, 0, 2); // 01:00:00, reminder lags
        add(1, 2, 1,     1, 32'h0001_0001, 0, 0, 1, 2);
        add(1, 1, 0, 78881, 32'h0023_5959, 0, 0, 1, 2); // tod at 23:59:59
        add(1, 1, 1,     0, 32'h0022_5442, 0, 0, 1, 2);
        add(1, 1, 0,     1, 32'h0000_0000, 0, 0, 1, 2); // tod wraps
        add(1, 1, 0,     5, 32'h0000_0005, 0, 0, 1, 2);
        add(0, 1, 0,     3, 32'h0000_0005, 0, 0, 1, 2); // frozen while off
        add(0, 1, 1,     0, 32'h0022_5448, 0, 0, 1, 2); // cum retained
        add(0, 1, 3,     0, 32'h0000_0000, 0, 0, 1, 2); // blank
        add(1, 0, 0,     1, 32'h0000_0000, 0, 0, 1, 2); // power cycle clears tod
        add(1, 1, 1,     1, 32'h0022_5449, 0, 0, 1, 2);
        add(1, 3, 2,     1, 32'h0000_0100, 0, 1, 1, 2);
        add(1, 4, 2,     1, 32'h0000_0300, 0, 1, 1, 2); // 3->4 reload
        add(1, 3, 2,     1, 32'h0000_0100, 0, 1, 1, 2); // 4->3 reload
        add(1, 5, 2,     1, 32'h0000_0000, 0, 0, 1, 2); // mode 5 = standby, abort
        add(1, 3, 2,     1, 32'h0000_0100, 0, 1, 1, 2);
        add(0, 3, 2,     1, 32'h0000_0000, 0, 0, 1, 2); // power-off abort
        add(1, 3, 2,     1, 32'h0000_0100, 0, 1, 1, 2);
        add(1, 3, 2,    59, 32'h0000_0001, 0, 1, 1, 2);
        add(1, 4, 2,     1, 32'h0000_0300, 0, 1, 1, 2); // change on expiry tick wins
        add(1, 4, 0,     0, 32'h0000_0100, 0, 1, 1, 2); // tod 00:01:00 since power rise

        for (int i = 0; i < tbl.size(); i++) begin
            power_on = tbl[i].pwr; mode = tbl[i].md; disp_sel = tbl[i].sel;
            if (tbl[i].n == 0) #1;
            else repeat (tbl[i].n) @(negedge clk_1hz);
            chk($sformatf("v%0d_data", i), time_data, tbl[i].data);
            chk($sformatf("v%0d_done", i), {31'b0, cd_done}, {31'b0, tbl[i].done});
            chk($sformatf("v%0d_act", i), {31'b0, cd_active}, {31'b0, tbl[i].act});
            chk($sformatf("v%0d_rem", i), {31'b0, clean_reminder}, {31'b0, tbl[i].rem});
            chk($sformatf("v%0d_dcnt", i), done_cnt, tbl[i].dcnt);
        end

        // ---------------- async reset mid-countdown ----------------
        disp_sel = 2'd2;
        @(negedge clk_1hz);
        chk("mid_cd_run", time_data, 32'h0000_0259);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_cd", time_data, 32'h0);
        chk("async_rst_act", {31'b0, cd_active}, 32'h0);
        chk("async_rst_rem", {31'b0, clean_reminder}, 32'h0);
        disp_sel = 2'd0;
        #1;
        chk("async_rst_tod", time_data, 32'h0);
        @(negedge clk_1hz);
        rst = 1'b1; disp_sel = 2'd2;
        @(negedge clk_1hz);
        chk("post_rst_reload", time_data, 32'h0000_0300);
        chk("post_rst_act", {31'b0, cd_active}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
